// File: rtl/avl_burst_pkg.sv
// rtl/avl_burst_pkg.sv - shared state type and address helper for the Avalon burst splitter
package avl_burst_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DRAIN = 2'd2,
    WR_BURST = 2'd3
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_MAX_W = 64;

  // Aligns to a word and steps one word; callers truncate to their width so the address wraps.
  function automatic logic [ADDR_MAX_W-1:0] next_word_addr(input logic [ADDR_MAX_W-1:0] addr);
    return (addr & ~ADDR_MAX_W'(WORD_BYTES - 1)) + ADDR_MAX_W'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/avl_burst_splitter.sv
// rtl/avl_burst_splitter.sv - splits s0 Avalon-MM bursts into single-word m0 accesses; BURST_SPLIT_RD_PIPE_EN pipelines reads
module avl_burst_splitter
  import avl_burst_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int BURST_W     = 8,
  parameter int MAX_PENDING = 4
) (
  input  logic              clk,
  input  logic              rest,
  input  logic [ADDR_W-1:0] s0_address,
  input  logic [3:0]        s0_byteEnable,
  input  logic              s0_read,
  input  logic              s0_write,
  input  logic [31:0]       s0_writeData,
  input  logic              s0_beginBurstTransfer,
  input  logic [BURST_W-1:0] s0_burstCount,
  output logic [31:0]       s0_readData,
  output logic              s0_readDataValid,
  output logic              s0_waitRequest,
  output logic [ADDR_W-1:0] m0_address,
  output logic [3:0]        m0_byteEnable,
  output logic              m0_read,
  output logic              m0_write,
  output logic [31:0]       m0_writeData,
  input  logic [31:0]       m0_readData,
  input  logic              m0_waitRequest,
  input  logic              m0_readDataValid
);

  localparam int PEND_W = $clog2(MAX_PENDING + 1);
`ifdef BURST_SPLIT_RD_PIPE_EN
  localparam logic [PEND_W-1:0] PEND_LIMIT = PEND_W'(MAX_PENDING);
`else
  localparam logic [PEND_W-1:0] PEND_LIMIT = PEND_W'(1);
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [BURST_W-1:0]  cnt_q;
  logic [BURST_W-1:0]  ret_q;
  logic [3:0]          be_q;
  logic [PEND_W-1:0]   pend_q;

  logic [BURST_W-1:0]  first_cnt;
  logic [ADDR_W-1:0]   s0_word_addr;
  logic [ADDR_W-1:0]   s0_next_addr;
  logic [ADDR_W-1:0]   addr_next;
  logic                issue_fire;
  logic                wr_fire;
  logic                rd_ret;
  logic                in_read;
  logic                unused_begin;

  // The first-beat marker carries no information the burst count does not already give.
  assign unused_begin = s0_beginBurstTransfer;

  assign first_cnt    = (s0_burstCount == '0) ? BURST_W'(1) : s0_burstCount;
  assign s0_word_addr = {s0_address[ADDR_W-1:2], 2'b00};
  assign s0_next_addr = ADDR_W'(next_word_addr(ADDR_MAX_W'(s0_address)));
  assign addr_next    = ADDR_W'(next_word_addr(ADDR_MAX_W'(addr_q)));
  assign in_read      = (state_q == RD_ISSUE) || (state_q == RD_DRAIN);
  assign issue_fire   = m0_read && !m0_waitRequest;
  assign wr_fire      = m0_write && !m0_waitRequest;
  assign rd_ret       = m0_readDataValid && in_read;

  // State register.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode; a write present in IDLE always beats a read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (s0_write) begin
          if (!m0_waitRequest && (first_cnt > BURST_W'(1))) state_d = WR_BURST;
        end else if (s0_read) begin
          state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: if (issue_fire && (cnt_q == BURST_W'(1))) state_d = RD_DRAIN;
      RD_DRAIN: if (rd_ret && (ret_q == BURST_W'(1))) state_d = IDLE;
      WR_BURST: if (wr_fire && (cnt_q == BURST_W'(1))) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Burst address, beat/return counters and the outstanding-read count.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      addr_q <= '0;
      cnt_q  <= '0;
      ret_q  <= '0;
      be_q   <= '0;
      pend_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          pend_q <= '0;
          if (s0_write) begin
            if (!m0_waitRequest) begin
              addr_q <= s0_next_addr;
              cnt_q  <= first_cnt - BURST_W'(1);
            end
          end else if (s0_read) begin
            addr_q <= s0_word_addr;
            cnt_q  <= first_cnt;
            ret_q  <= first_cnt;
            be_q   <= s0_byteEnable;
          end
        end
        RD_ISSUE, RD_DRAIN: begin
          if (issue_fire) begin
            addr_q <= addr_next;
            cnt_q  <= cnt_q - BURST_W'(1);
          end
          if (rd_ret) ret_q <= ret_q - BURST_W'(1);
          case ({issue_fire, rd_ret})
            2'b10:   pend_q <= pend_q + PEND_W'(1);
            2'b01:   pend_q <= pend_q - PEND_W'(1);
            default: pend_q <= pend_q;
          endcase
        end
        WR_BURST: begin
          if (wr_fire) begin
            addr_q <= addr_next;
            cnt_q  <= cnt_q - BURST_W'(1);
          end
        end
        default: pend_q <= '0;
      endcase
    end
  end

  // Output decode; everything is held quiet while reset is asserted.
  always_comb begin
    s0_waitRequest   = 1'b1;
    s0_readData      = '0;
    s0_readDataValid = 1'b0;
    m0_address       = '0;
    m0_byteEnable    = '0;
    m0_read          = 1'b0;
    m0_write         = 1'b0;
    m0_writeData     = '0;
    if (!rest) begin
      case (state_q)
        IDLE: begin
          if (s0_write) begin
            m0_write       = 1'b1;
            m0_address     = s0_word_addr;
            m0_byteEnable  = s0_byteEnable;
            m0_writeData   = s0_writeData;
            s0_waitRequest = m0_waitRequest;
          end else begin
            s0_waitRequest = 1'b0;
          end
        end
        RD_ISSUE: begin
          m0_read       = (pend_q < PEND_LIMIT);
          m0_address    = addr_q;
          m0_byteEnable = be_q;
        end
        WR_BURST: begin
          m0_write       = s0_write;
          m0_address     = addr_q;
          m0_byteEnable  = s0_byteEnable;
          m0_writeData   = s0_writeData;
          s0_waitRequest = (s0_read && !s0_write) ? 1'b1 : m0_waitRequest;
        end
        default: s0_waitRequest = 1'b1;
      endcase
      if (in_read) begin
        s0_readData      = m0_readData;
        s0_readDataValid = m0_readDataValid;
      end
    end
  end

endmodule

// File: tb/tb_avl_burst_splitter.sv
// tb/tb_avl_burst_splitter.sv - randomized self-checking bench for avl_burst_splitter
module tb_avl_burst_splitter;

  localparam int ADDR_W = 32;
  localparam int BURST_W = 8;
  localparam int MAX_PENDING = 4;
`ifdef BURST_SPLIT_RD_PIPE_EN
  localparam int LIMIT = MAX_PENDING;
`else
  localparam int LIMIT = 1;
`endif

  logic clk = 1'b0;
  logic rest = 1'b1;
  logic [ADDR_W-1:0] s0_address;
  logic [3:0] s0_byteEnable;
  logic s0_read, s0_write, s0_beginBurstTransfer;
  logic [31:0] s0_writeData;
  logic [BURST_W-1:0] s0_burstCount;
  logic [31:0] s0_readData;
  logic s0_readDataValid, s0_waitRequest;
  logic [ADDR_W-1:0] m0_address;
  logic [3:0] m0_byteEnable;
  logic m0_read, m0_write;
  logic [31:0] m0_writeData, m0_readData;
  logic m0_waitRequest, m0_readDataValid;

  always #5 clk = ~clk;

  avl_burst_splitter #(.ADDR_W(ADDR_W), .BURST_W(BURST_W), .MAX_PENDING(MAX_PENDING)) dut (
    .clk(clk), .rest(rest),
    .s0_address(s0_address), .s0_byteEnable(s0_byteEnable), .s0_read(s0_read),
    .s0_write(s0_write), .s0_writeData(s0_writeData),
    .s0_beginBurstTransfer(s0_beginBurstTransfer), .s0_burstCount(s0_burstCount),
    .s0_readData(s0_readData), .s0_readDataValid(s0_readDataValid),
    .s0_waitRequest(s0_waitRequest),
    .m0_address(m0_address), .m0_byteEnable(m0_byteEnable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writeData(m0_writeData), .m0_readData(m0_readData),
    .m0_waitRequest(m0_waitRequest), .m0_readDataValid(m0_readDataValid)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } acc_t;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  acc_t exp_m0 [$];
  logic [31:0] exp_rd [$];
  logic [31:0] rd_log [$];

  int lat = 1;
  int wait_mode = 0;
  int stall_left = 0;
  int wr_seen = 0;
  int stall_seen = 0;
  int m0_rd_seen = 0;
  logic inject = 1'b0;
  logic flush = 1'b0;
  logic pv [8];
  logic [31:0] pd [8];

  logic [31:0] wdata [16];
  logic [3:0] wbe [16];
  int gap [16];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-beat memory slave with fixed read latency and selectable wait behaviour.
  logic s_wa, s_ra;
  logic [31:0] s_addr, s_data;
  logic [3:0] s_be;
  always begin
    @(negedge clk);
    s_wa = m0_write && !m0_waitRequest && !rest;
    s_ra = m0_read && !m0_waitRequest && !rest;
    s_addr = m0_address;
    s_data = m0_writeData;
    s_be = m0_byteEnable;
    @(posedge clk);
    #1;
    if (s_wa) begin
      mem[s_addr[11:2]] = merge(mem[s_addr[11:2]], s_data, s_be);
      wr_seen++;
      if (wait_mode == 2 && wr_seen == 1) stall_left = 2;
    end
    for (int i = 0; i < 7; i++) begin
      pv[i] = pv[i+1];
      pd[i] = pd[i+1];
    end
    pv[7] = 1'b0;
    if (s_ra) begin
      pv[lat-1] = 1'b1;
      pd[lat-1] = mem[s_addr[11:2]];
    end
    if (flush) for (int i = 0; i < 8; i++) pv[i] = 1'b0;
    m0_readDataValid = pv[0] || inject;
    m0_readData = pv[0] ? pd[0] : (inject ? 32'hDEADBEEF : $urandom);
    inject = 1'b0;
    case (wait_mode)
      1: m0_waitRequest = ($urandom_range(0, 3) == 0);
      2: begin
        m0_waitRequest = (stall_left > 0);
        if (stall_left > 0) stall_left--;
      end
      default: m0_waitRequest = 1'b0;
    endcase
  end

  // Compare process: every accepted m0 access and every s0 read beat against the model.
  acc_t cmp_e;
  int pend_now;
  always @(negedge clk) begin
    if (!rest) begin
      pend_now = 0;
      for (int i = 0; i < 8; i++) if (pv[i]) pend_now++;
      if (m0_write && m0_waitRequest) stall_seen++;
      if (m0_read && m0_write) check("m0_rd_wr_exclusive", {m0_read, m0_write}, 2'b10);
      if ((m0_read || m0_write) && !m0_waitRequest) begin
        if (m0_read) begin
          m0_rd_seen++;
          checks++;
          if (pend_now >= LIMIT) begin
            errors++;
            $display("FAIL m0_outstanding: got %0d pending at issue, limit %0d", pend_now, LIMIT);
          end
        end
        checks++;
        if (exp_m0.size() == 0) begin
          errors++;
          $display("FAIL m0_unexpected: got we=%0d addr=0x%0h, no access expected", m0_write, m0_address);
        end else begin
          cmp_e = exp_m0.pop_front();
          if (m0_write !== cmp_e.we || m0_address !== cmp_e.addr || m0_byteEnable !== cmp_e.be ||
              (cmp_e.we && m0_writeData !== cmp_e.data)) begin
            errors++;
            $display("FAIL m0_access: got we=%0d addr=0x%0h be=0x%0h data=0x%0h want we=%0d addr=0x%0h be=0x%0h data=0x%0h",
                     m0_write, m0_address, m0_byteEnable, m0_writeData, cmp_e.we, cmp_e.addr, cmp_e.be, cmp_e.data);
          end
        end
      end
      if (s0_readDataValid) begin
        rd_log.push_back(s0_readData);
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL s0_unexpected_read: got 0x%0h, no beat expected", s0_readData);
        end else if (s0_readData !== exp_rd[0]) begin
          errors++;
          $display("FAIL s0_read_data: got 0x%0h want 0x%0h", s0_readData, exp_rd[0]);
          void'(exp_rd.pop_front());
        end else begin
          void'(exp_rd.pop_front());
        end
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input int cnt, input bit both_rd);
    int beats, n;
    logic [31:0] a;
    bit acc;
    beats = (cnt == 0) ? 1 : cnt;
    for (int k = 0; k < beats; k++) begin
      a = {addr[31:2], 2'b00} + 32'(4 * k);
      exp_m0.push_back('{we: 1'b1, addr: a, data: wdata[k], be: wbe[k]});
      ref_mem[a[11:2]] = merge(ref_mem[a[11:2]], wdata[k], wbe[k]);
    end
    for (int k = 0; k < beats; k++) begin
      s0_write = 1'b1;
      s0_writeData = wdata[k];
      s0_byteEnable = wbe[k];
      if (k == 0) begin
        s0_address = addr;
        s0_burstCount = BURST_W'(cnt);
        s0_beginBurstTransfer = 1'b1;
        s0_read = both_rd;
      end else begin
        s0_address = $urandom;
        s0_burstCount = BURST_W'($urandom);
      end
      n = 0;
      acc = 1'b0;
      while (!acc && n < 200) begin
        @(negedge clk);
        acc = !s0_waitRequest;
        tick();
        n++;
      end
      if (!acc) check("write_beat_timeout", 64'(n), 64'(0));
      s0_read = 1'b0;
      s0_beginBurstTransfer = 1'b0;
      if (k < beats - 1 && gap[k] > 0) begin
        s0_write = 1'b0;
        repeat (gap[k]) begin
          @(negedge clk);
          check("gap_no_m0_write", 64'(m0_write), 64'(0));
          tick();
        end
      end
    end
    s0_write = 1'b0;
    check("write_m0_all_done", 64'(exp_m0.size()), 64'(0));
  endtask

  task automatic do_read(input logic [31:0] addr, input int cnt, input logic [3:0] be);
    int beats, n;
    logic [31:0] a;
    bit acc;
    beats = (cnt == 0) ? 1 : cnt;
    for (int k = 0; k < beats; k++) begin
      a = {addr[31:2], 2'b00} + 32'(4 * k);
      exp_m0.push_back('{we: 1'b0, addr: a, data: 32'h0, be: be});
      exp_rd.push_back(ref_mem[a[11:2]]);
    end
    s0_read = 1'b1;
    s0_address = addr;
    s0_burstCount = BURST_W'(cnt);
    s0_byteEnable = be;
    s0_beginBurstTransfer = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = !s0_waitRequest;
      tick();
      n++;
    end
    if (!acc) check("read_cmd_timeout", 64'(n), 64'(0));
    s0_read = 1'b0;
    s0_beginBurstTransfer = 1'b0;
    n = 0;
    while (exp_rd.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    check("read_returns_done", 64'(exp_rd.size()), 64'(0));
    check("read_m0_all_done", 64'(exp_m0.size()), 64'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, cnt, mm;
    logic [31:0] a;
    s0_address = 32'h1234; s0_byteEnable = 4'hF; s0_read = 1'b1; s0_write = 1'b1;
    s0_writeData = 32'hCAFE0000; s0_beginBurstTransfer = 1'b0; s0_burstCount = '0;
    m0_waitRequest = 1'b0; m0_readDataValid = 1'b0; m0_readData = '0;
    for (int i = 0; i < 8; i++) begin pv[i] = 1'b0; pd[i] = '0; end
    for (int i = 0; i < 1024; i++) begin mem[i] = 32'(i * i); ref_mem[i] = 32'(i * i); end

    // Reset state with both commands asserted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_waitrequest", 64'(s0_waitRequest), 64'(1));
    check("rst_m0_read", 64'(m0_read), 64'(0));
    check("rst_m0_write", 64'(m0_write), 64'(0));
    check("rst_m0_address", 64'(m0_address), 64'(0));
    check("rst_rdvalid", 64'(s0_readDataValid), 64'(0));
    @(posedge clk);
    #1;
    s0_read = 1'b0; s0_write = 1'b0;
    rest = 1'b0;
    @(negedge clk);
    check("wait_drops_after_reset", 64'(s0_waitRequest), 64'(0));
    tick();

    // Read burst of 8 from 0x100 on zero-wait memory holding i*i.
    lat = 1; wait_mode = 0;
    rd_log.delete();
    do_read(32'h100, 8, 4'hF);
    check("rd8_beats", 64'(rd_log.size()), 64'(8));
    if (rd_log.size() == 8) begin
      check("rd8_b0", 64'(rd_log[0]), 64'(4096));
      check("rd8_b1", 64'(rd_log[1]), 64'(4225));
      check("rd8_b2", 64'(rd_log[2]), 64'(4356));
      check("rd8_b7", 64'(rd_log[7]), 64'(5041));
    end
    @(negedge clk);
    check("idle_after_rd8", 64'(s0_waitRequest), 64'(0));
    tick();

    // Write burst with a 2-cycle stall on beat 2, then read back.
    wait_mode = 2; wr_seen = 0; stall_seen = 0;
    for (int k = 0; k < 4; k++) begin wdata[k] = 32'(k + 1); wbe[k] = 4'hF; gap[k] = 0; end
    do_write(32'h40, 4, 1'b0);
    wait_mode = 0;
    check("wr_stall_cycles", 64'(stall_seen), 64'(2));
    rd_log.delete();
    do_read(32'h40, 4, 4'hF);
    check("wr4_readback", {rd_log[0][7:0], rd_log[1][7:0], rd_log[2][7:0], rd_log[3][7:0]}, 64'h01020304);

    // Write burst with a 3-cycle bubble after beat 1.
    for (int k = 0; k < 4; k++) begin wdata[k] = 32'hA0 + 32'(k); wbe[k] = 4'hF; gap[k] = 0; end
    gap[0] = 3;
    do_write(32'h200, 4, 1'b0);
    gap[0] = 0;
    rd_log.delete();
    do_read(32'h200, 4, 4'hF);
    check("gap_readback_b0", 64'(rd_log[0]), 64'hA0);
    check("gap_readback_b3", 64'(rd_log[3]), 64'hA3);

    // Partial byte-enable single write, count-1 readback.
    wdata[0] = 32'h12345678; wbe[0] = 4'hC;
    do_write(32'h4, 1, 1'b0);
    rd_log.delete();
    do_read(32'h4, 1, 4'hF);
    check("be_merge", 64'(rd_log[0]), 64'h12340001);

    // Burst count 0 is a single beat; address wraps past the top.
    rd_log.delete();
    do_read(32'h10, 0, 4'h3);
    check("count0_one_beat", 64'(rd_log.size()), 64'(1));
    do_read(32'hFFFF_FFF9, 4, 4'hF);

    // Reset while issuing a read burst, after three issues.
    lat = 1; wait_mode = 0; m0_rd_seen = 0;
    for (int k = 0; k < 8; k++) begin
      a = 32'h300 + 32'(4 * k);
      exp_m0.push_back('{we: 1'b0, addr: a, data: 32'h0, be: 4'hF});
      exp_rd.push_back(ref_mem[a[11:2]]);
    end
    s0_read = 1'b1; s0_address = 32'h300; s0_burstCount = 8'd8; s0_byteEnable = 4'hF;
    tick();
    s0_read = 1'b0;
    n = 0;
    while (m0_rd_seen < 3 && n < 200) begin tick(); n++; end
    check("rst_mid_three_issued", 64'(m0_rd_seen), 64'(3));
    n = 0;
    while (!m0_read && n < 50) begin tick(); n++; end
    check("rst_mid_m0_read_pending", 64'(m0_read), 64'(1));
    #1;
    rest = 1'b1;
    #1;
    check("rst_mid_m0_read", 64'(m0_read), 64'(0));
    check("rst_mid_waitrequest", 64'(s0_waitRequest), 64'(1));
    flush = 1'b1;
    exp_m0.delete();
    exp_rd.delete();
    repeat (2) tick();
    rest = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    inject = 1'b1;
    tick();
    @(negedge clk);
    check("stray_valid_dropped", 64'(s0_readDataValid), 64'(0));
    tick();
    rd_log.delete();
    do_read(32'h300, 2, 4'hF);
    check("post_rst_beats", 64'(rd_log.size()), 64'(2));
    if (rd_log.size() == 2) begin
      check("post_rst_b0", 64'(rd_log[0]), 64'(36864));
      check("post_rst_b1", 64'(rd_log[1]), 64'(37249));
    end

    // Randomized bursts against the model.
    for (int t = 0; t < 60; t++) begin
      lat = $urandom_range(1, 4);
      wait_mode = $urandom_range(0, 1);
      cnt = $urandom_range(0, 9);
      a = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
      if ($urandom_range(0, 1) == 0) begin
        for (int k = 0; k < 16; k++) begin
          wdata[k] = $urandom;
          wbe[k] = 4'($urandom);
          gap[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        end
        do_write(a, cnt, ($urandom_range(0, 3) == 0));
      end else begin
        do_read(a, cnt, 4'($urandom));
      end
      if ($urandom_range(0, 1) == 0) tick();
    end

    // Physical memory must match the model's image.
    mm = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mm++;
    check("final_mem_image", 64'(mm), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
